// File: rtl/varcic_sat.sv
// Runtime-variable CIC decimator with per-ratio gain normalisation, round-half-up
// and saturation; any ratio change flushes the filter and re-enters settling.
module varcic_sat #(
    parameter int unsigned STAGES    = 5,
    parameter int unsigned IN_WIDTH  = 18,
    parameter int unsigned OUT_WIDTH = 18,
    parameter int unsigned DEC_WIDTH = 6,
    parameter int unsigned ACC_WIDTH = 48
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic [DEC_WIDTH-1:0]        decimation,
    input  logic                        in_strobe,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    output logic                        out_strobe,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        settling
);

    localparam int unsigned NUM_RATIOS = 2 ** DEC_WIDTH;
    localparam int unsigned GW         = $clog2(STAGES * DEC_WIDTH + 1);
    localparam int unsigned SCW        = $clog2(STAGES + 2);
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};

    if (ACC_WIDTH < IN_WIDTH + STAGES * DEC_WIDTH) begin : g_bad_acc
        $error("varcic_sat: ACC_WIDTH cannot hold worst-case growth");
    end
    if (OUT_WIDTH > IN_WIDTH) begin : g_bad_out
        $error("varcic_sat: OUT_WIDTH must not exceed IN_WIDTH");
    end

    // Smallest G with 2^G >= r^STAGES, i.e. ceil(STAGES*log2(r)).
    function automatic int unsigned growth_of(input int unsigned r);
        logic [ACC_WIDTH:0] pw;
        logic [ACC_WIDTH:0] lim;
        int unsigned        g;
        pw = (ACC_WIDTH+1)'(1);
        for (int i = 0; i < int'(STAGES); i++) begin
            pw = pw * (ACC_WIDTH+1)'(r);
        end
        lim = (ACC_WIDTH+1)'(1);
        g   = 0;
        for (int i = 0; i <= int'(ACC_WIDTH); i++) begin
            if (lim < pw) begin
                lim = lim << 1;
                g   = g + 1;
            end
        end
        return g;
    endfunction

    logic [GW-1:0] growth_rom [NUM_RATIOS];
    for (genvar r = 0; r < int'(NUM_RATIOS); r++) begin : g_rom
        assign growth_rom[r] = GW'(growth_of(r));
    end

    logic signed [ACC_WIDTH-1:0] integ     [STAGES];
    logic signed [ACC_WIDTH-1:0] integ_nxt [STAGES];
    logic signed [ACC_WIDTH-1:0] dly       [STAGES];
    logic signed [ACC_WIDTH-1:0] comb_in   [STAGES];
    logic signed [ACC_WIDTH-1:0] int_acc;
    logic signed [ACC_WIDTH-1:0] comb_acc;
    logic signed [ACC_WIDTH-1:0] comb_q;
    logic [DEC_WIDTH-1:0]        dec_reg;
    logic [DEC_WIDTH-1:0]        cnt;
    logic                        tick;
    logic                        res_valid;
    logic [SCW-1:0]              settle_cnt;

    int                          shift;
    logic [OUT_WIDTH:0]          sel;
    logic signed [OUT_WIDTH-1:0] kept;
    logic                        rnd;
    logic signed [OUT_WIDTH-1:0] scaled;

    // Integrator cascade: every stage sees this sample's update of the one before.
    always_comb begin
        int_acc = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
        for (int k = 0; k < int'(STAGES); k++) begin
            int_acc      = integ[k] + int_acc;
            integ_nxt[k] = int_acc;
        end
    end

    // Comb cascade at the decimated rate, differential delay 1.
    always_comb begin
        comb_acc = integ[STAGES-1];
        for (int k = 0; k < int'(STAGES); k++) begin
            comb_in[k] = comb_acc;
            comb_acc   = comb_acc - dly[k];
        end
    end

    // Normalise by 2^(IN_WIDTH+G-OUT_WIDTH), round half up, clamp the positive carry.
    always_comb begin
        shift = int'(IN_WIDTH) + int'(growth_rom[dec_reg]) - int'(OUT_WIDTH);
        sel   = '0;
        if (shift == 0) begin
            kept = OUT_WIDTH'(comb_q);
            rnd  = 1'b0;
        end else begin
            sel  = (OUT_WIDTH+1)'(comb_q >>> (shift - 1));
            kept = sel[OUT_WIDTH:1];
            rnd  = sel[0];
        end
        if (rnd && (kept == OUT_MAX)) begin
            scaled = OUT_MAX;
        end else begin
            scaled = kept + OUT_WIDTH'(rnd);
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                integ[k] <= '0;
                dly[k]   <= '0;
            end
            comb_q     <= '0;
            dec_reg    <= '0;
            cnt        <= '0;
            tick       <= 1'b0;
            res_valid  <= 1'b0;
            settle_cnt <= '0;
            settling   <= 1'b1;
            out_strobe <= 1'b0;
            out_data   <= '0;
        end else begin
            out_strobe <= 1'b0;
            if (decimation != dec_reg) begin
                // Ratio change: drop everything in flight, including this cycle's sample.
                for (int k = 0; k < int'(STAGES); k++) begin
                    integ[k] <= '0;
                    dly[k]   <= '0;
                end
                comb_q     <= '0;
                dec_reg    <= decimation;
                cnt        <= '0;
                tick       <= 1'b0;
                res_valid  <= 1'b0;
                settle_cnt <= '0;
                settling   <= 1'b1;
            end else if (dec_reg != '0) begin
                tick      <= 1'b0;
                res_valid <= tick;
                if (in_strobe) begin
                    for (int k = 0; k < int'(STAGES); k++) begin
                        integ[k] <= integ_nxt[k];
                    end
                    if (cnt == dec_reg - DEC_WIDTH'(1)) begin
                        cnt  <= '0;
                        tick <= 1'b1;
                    end else begin
                        cnt <= cnt + DEC_WIDTH'(1);
                    end
                end
                if (tick) begin
                    for (int k = 0; k < int'(STAGES); k++) begin
                        dly[k] <= comb_in[k];
                    end
                    comb_q <= comb_acc;
                end
                if (res_valid) begin
                    if (settle_cnt == SCW'(STAGES + 1)) begin
                        out_strobe <= 1'b1;
                        out_data   <= scaled;
                    end else begin
                        settle_cnt <= settle_cnt + SCW'(1);
                        if (settle_cnt == SCW'(STAGES)) begin
                            settling <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_varcic_sat.sv
// Bench for varcic_sat: an 18-bit and a 16-bit output instance share stimulus and
// are compared every cycle against a convolution-based CIC reference model.
module tb_varcic_sat;

    localparam int N  = 5;
    localparam int IW = 18;

    logic               clock      = 1'b0;
    logic               rst        = 1'b1;
    logic [5:0]         decimation = '0;
    logic               in_strobe  = 1'b0;
    logic signed [17:0] in_data    = '0;

    logic               os18, st18, os16, st16;
    logic signed [17:0] od18;
    logic signed [15:0] od16;

    always #5 clock = ~clock;

    varcic_sat #(.STAGES(5), .IN_WIDTH(18), .OUT_WIDTH(18), .DEC_WIDTH(6), .ACC_WIDTH(48)) dut18 (
        .clock(clock), .rst(rst), .decimation(decimation), .in_strobe(in_strobe),
        .in_data(in_data), .out_strobe(os18), .out_data(od18), .settling(st18));

    varcic_sat #(.STAGES(5), .IN_WIDTH(18), .OUT_WIDTH(16), .DEC_WIDTH(6), .ACC_WIDTH(48)) dut16 (
        .clock(clock), .rst(rst), .decimation(decimation), .in_strobe(in_strobe),
        .in_data(in_data), .out_strobe(os16), .out_data(od16), .settling(st16));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        longint due;
        longint y;
    } pend_t;

    int     m_dec   = 0;
    longint hist[$];
    longint m_n     = 0;
    pend_t  pend[$];
    int     m_res   = 0;
    longint m_edge  = 0;
    logic   e_strobe = 1'b0;
    logic   e_settle = 1'b1;
    longint e_d18   = 0;
    longint e_d16   = 0;

    function automatic int growth(input int r);
        longint p;
        int     g;
        p = 1;
        repeat (N) p = p * r;
        g = 0;
        while ((longint'(1) << g) < p) g++;
        return g;
    endfunction

    function automatic longint scale(input longint y, input int r, input int ow);
        int     s;
        longint q, mx, mn;
        s = IW + growth(r) - ow;
        q = (s == 0) ? y : ((y + (longint'(1) << (s - 1))) >>> s);
        mx = (longint'(1) << (ow - 1)) - 1;
        mn = -(longint'(1) << (ow - 1));
        if (q > mx) q = mx;
        if (q < mn) q = mn;
        return q;
    endfunction

    // Ideal CIC output: samples since flush convolved with (1+z+...+z^(r-1))^N.
    function automatic longint cic_y(input int r);
        longint h[$];
        longint t[$];
        longint y;
        int     idx;
        h.push_back(1);
        repeat (N) begin
            t.delete();
            for (int i = 0; i < h.size() + r - 1; i++) t.push_back(0);
            for (int i = 0; i < h.size(); i++)
                for (int j = 0; j < r; j++) t[i+j] += h[i];
            h = t;
        end
        y = 0;
        for (int j = 0; j < h.size(); j++) begin
            idx = hist.size() - 1 - j;
            if (idx >= 0) y += h[j] * hist[idx];
        end
        return y;
    endfunction

    always @(posedge clock or posedge rst) begin
        if (rst) begin
            m_dec = 0; hist.delete(); m_n = 0; pend.delete(); m_res = 0;
            e_strobe = 1'b0; e_settle = 1'b1; e_d18 = 0; e_d16 = 0;
        end else begin
            e_strobe = 1'b0;
            if (int'(decimation) != m_dec) begin
                m_dec = int'(decimation);
                hist.delete(); m_n = 0; pend.delete(); m_res = 0;
                e_settle = 1'b1;
            end else if (m_dec != 0) begin
                if (pend.size() > 0 && pend[0].due == m_edge) begin
                    if (m_res < N + 1) begin
                        m_res++;
                        if (m_res == N + 1) e_settle = 1'b0;
                    end else begin
                        e_strobe = 1'b1;
                        e_d18 = scale(pend[0].y, m_dec, 18);
                        e_d16 = scale(pend[0].y, m_dec, 16);
                    end
                    void'(pend.pop_front());
                end
                if (in_strobe) begin
                    hist.push_back(longint'(in_data));
                    if (hist.size() > 400) void'(hist.pop_front());
                    m_n++;
                    if (m_n % m_dec == 0) pend.push_back('{m_edge + 2, cic_y(m_dec)});
                end
            end
            m_edge++;
        end
    end

    // Continuous comparison of both instances against the model.
    always @(negedge clock) begin
        chk("strobe18", longint'(os18), longint'(e_strobe));
        chk("settle18", longint'(st18), longint'(e_settle));
        chk("data18",   longint'(od18), e_d18);
        chk("strobe16", longint'(os16), longint'(e_strobe));
        chk("settle16", longint'(st16), longint'(e_settle));
        chk("data16",   longint'(od16), e_d16);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int dec, input logic stb, input longint data);
        @(negedge clock);
        decimation = 6'(dec);
        in_strobe  = stb;
        in_data    = 18'(data);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int rset[8];
        int cur;
        int k;
        int cnt;
        rset = '{1, 2, 3, 5, 8, 17, 63, 0};

        chk("pin_g5", growth(5), 12);
        chk("pin_g6", growth(6), 13);
        chk("pin_g8", growth(8), 15);
        chk("pin_scale_r8", scale(1000 * 32768, 8, 18), 1000);
        chk("pin_scale_r5", scale(1000 * 3125, 5, 18), 763);
        chk("pin_scale_r6", scale(1000 * 7776, 6, 18), 949);
        chk("pin_sat16", scale(131071, 1, 16), 32767);
        chk("pin_neg16", scale(-131072, 1, 16), -32768);

        decimation = 6'd8;
        repeat (3) @(negedge clock);
        chk("rst_strobe", longint'(os18), 0);
        chk("rst_data", longint'(od18), 0);
        chk("rst_settle", longint'(st18), 1);
        rst = 1'b0;

        // R=8 DC: gain exactly one
        repeat (120) drive(8, 1'b1, 1000);
        chk("r8_dc", longint'(od18), 1000);
        chk("r8_settled", longint'(st18), 0);

        // R=5 DC with gappy strobes
        for (int i = 0; i < 200; i++) drive(5, ($urandom_range(0, 9) < 7), 1000);
        chk("r5_dc", longint'(od18), 763);

        // Random data, strobes and ratio changes
        cur = 3;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 149) == 0) cur = rset[$urandom_range(0, 7)];
            drive(cur, ($urandom_range(0, 3) != 0), longint'($signed(18'($urandom))));
        end

        // R=1 saturation on the 16-bit instance
        repeat (30) drive(1, 1'b1, 131071);
        chk("sat_pos16", longint'(od16), 32767);
        chk("sat_pos18", longint'(od18), 131071);
        repeat (10) drive(1, 1'b1, -131072);
        chk("sat_neg16", longint'(od16), -32768);
        chk("sat_neg18", longint'(od18), -131072);

        // R=4 steady, then change to 6 together with a strobe
        repeat (61) drive(4, 1'b1, 1000);
        drive(6, 1'b1, 1000);
        drive(6, 1'b1, 1000);
        chk("chg_nostrobe1", longint'(os18), 0);
        chk("chg_settle1", longint'(st18), 1);
        drive(6, 1'b1, 1000);
        chk("chg_nostrobe2", longint'(os18), 0);
        chk("chg_settle2", longint'(st18), 1);
        repeat (80) drive(6, 1'b1, 1000);
        chk("chg_r6_dc", longint'(od18), 949);

        // Reset pulse with a result in flight
        repeat (60) drive(4, 1'b1, 1000);
        k = 0;
        do begin
            @(negedge clock);
            decimation = 6'd4; in_strobe = 1'b1; in_data = 18'sd1000;
            @(posedge clock);
            #1;
            k++;
        end while ((m_n % 4 != 0) && k < 10);
        chk("rstp_aligned", longint'(m_n % 4), 0);
        in_strobe = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rstp_data", longint'(od18), 0);
        chk("rstp_settle", longint'(st18), 1);
        chk("rstp_strobe", longint'(os18), 0);
        @(negedge clock);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive(4, 1'b1, 1000);
            cnt += int'(os18);
        end
        chk("rstp_no_late_strobe", cnt, 0);
        repeat (80) drive(4, 1'b1, 1000);
        chk("rstp_resume", longint'(od18), 1000);

        // Ratio 0: idle
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            drive(0, 1'b1, $urandom_range(0, 5000));
            cnt += int'(os18) + int'(os16);
        end
        chk("idle_strobes", cnt, 0);
        chk("idle_settle", longint'(st18), 1);
        chk("idle_hold", longint'(od18), 1000);

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/varcic_sat.md
# varcic_sat

Runtime-variable CIC decimator, successor to the fixed-table CIC in the receive chain. Any decimation ratio 1..2^DEC_WIDTH-1 is accepted. Gain normalisation is computed per ratio from a build-time growth table; output uses round-half-up with saturation. Any ratio change triggers a clean flush and resettle. It sits between the CORDIC/mixer output and the FIR decimator, one instance per I/Q rail.

## Interface
- STAGES, 5: integrator/comb stage count N.
- IN_WIDTH, 18: signed input width.
- OUT_WIDTH, 18: signed output width; must be ≤ IN_WIDTH.
- DEC_WIDTH, 6: ratio port width; max ratio 2^DEC_WIDTH-1.
- ACC_WIDTH, 48: accumulator width; must be ≥ IN_WIDTH + STAGES*DEC_WIDTH (elaboration error otherwise).
- clock  in  1  sole clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- decimation  in  DEC_WIDTH  ratio R; sampled every cycle.
- in_strobe  in  1  input sample valid, one-cycle pulse.
- in_data  in  IN_WIDTH  signed sample, valid with in_strobe.
- out_strobe  out  1  one-cycle pulse; out_data updated on the same edge.
- out_data  out  OUT_WIDTH  signed decimated sample, held between strobes.
- settling  out  1  high while outputs are suppressed after reset or ratio change.

## Operation
- Reset values:
  - out_strobe=0, out_data=0, settling=1.
  - All integrators, combs, sample counter and settle counter = 0.
  - Latched ratio dec_reg = 0.
- Ratio latch:
  - Every cycle, if decimation ≠ dec_reg: latch dec_reg<=decimation and flush all integrators, combs and the counter to 0.
  - Set settling=1 and settle_cnt=0.
  - Any in_strobe in that cycle is discarded.
- Ratio 0: block idle. No counting, no out_strobe, settling stays 1.
- Integrators: N registered stages, two's-complement wrap at ACC_WIDTH. Each updates on in_strobe; stage 0 takes sign-extended in_data.
- Counter: increments on in_strobe. At dec_reg-1 it wraps to 0 and raises internal dec_tick one cycle later. For R=1, every in_strobe produces a tick.
- Combs: N registered stages with differential delay 1, updated on dec_tick, wrapping at ACC_WIDTH.
- Growth: G = ceil(N*log2(R)), read from a ROM indexed by dec_reg and built by a constant function at elaboration.
- Scaling:
  - Take bits [IN_WIDTH+G-1 : IN_WIDTH+G-OUT_WIDTH] of the final comb, plus round bit IN_WIDTH+G-OUT_WIDTH-1 when that index ≥ 0.
  - If rounding carries past +max, saturate to 2^(OUT_WIDTH-1)-1. The negative side cannot overflow.
- Settling:
  - The first STAGES+1 results after a flush or reset update nothing: no out_strobe, out_data unchanged, settle_cnt increments.
  - When settle_cnt reaches STAGES+1, settling drops and subsequent results produce out_strobe.

## Timing
- in_strobe in cycle n completes the ratio: dec_tick at n+1, comb output registered at end of n+1, out_data/out_strobe registered at end of n+2.
- Latency: out_strobe high exactly 2 clocks after the completing in_strobe.
- in_strobe may be asserted every cycle for any R ≥ 1; throughput is one output per R input strobes.
- settling changes on the same edge as the flush and on the edge that would have produced the (STAGES+1)th result.
- Ratio change with a result in flight:
  - The in-flight dec_tick and output are cancelled.
  - No out_strobe occurs in the 2 cycles after the change.
- rst asserted mid-operation clears everything asynchronously. The first in_strobe is accepted on the first edge after deassertion.
- Simultaneous ratio change and in_strobe: the flush wins and the sample is dropped.

## Test plan
- R=8, N=5, in_data=1000 DC on every strobe → settling falls after 6 suppressed results; every out_data = 1000 (G=15, gain exactly 1).
- R=5, DC 1000 → G=12, gain 3125/4096; steady out_data = 763 (762.9 rounded half-up).
- OUT_WIDTH=16, R=1, DC 131071 → kept bits 32767 with round bit 1 → saturated out_data = 32767, never -32768. DC -131072 → -32768.
- R=4 steady, then decimation→6 mid-stream with in_strobe in the same cycle:
  - No out_strobe for 2 clocks; settling=1.
  - 6 results suppressed, then out_data settles at round(DC*7776/8192).
- rst pulse between an in_strobe and its out_strobe → out_strobe never fires; out_data=0 and settling=1 immediately. Normal operation resumes with 6 suppressed results.
- decimation=0 with continuous in_strobe for 100 cycles → no out_strobe; settling=1; out_data unchanged.
